// File: rtl/dm_result_checker.sv
// dm_result_checker: after a processor signals completion, scans NUM_CHECKS
// consecutive data-memory bytes starting at BASE_ADDR, compares each against
// a small expected-value table and reports a pass flag plus a per-byte
// mismatch mask.
// Optional feature: define CHECKER_TIMEOUT_EN to add a done-wait watchdog of
// TIMEOUT_CYCLES cycles; without it the checker waits for done indefinitely.
module dm_result_checker #(
    parameter int unsigned NUM_CHECKS     = 5,
    parameter logic [7:0]  BASE_ADDR      = 8'd1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       done,
    input  logic       exp_we,
    input  logic [2:0] exp_idx,
    input  logic [7:0] exp_data,
    output logic [7:0] dm_addr,
    input  logic [7:0] dm_data,
    output logic       busy,
    output logic       result_valid,
    output logic       pass,
    output logic [7:0] err_mask,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        SCAN,
        REPORT
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_CHECKS - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [7:0] r_exp [8];
    logic       r_valid;
    logic       r_pass;
    logic [7:0] r_err;
    logic       w_timeout;

`ifdef CHECKER_TIMEOUT_EN
    localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_cnt;
    logic        r_timeout;

    assign w_timeout = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    // The index is held at 0 outside SCAN, so the address is simply
    // BASE_ADDR+i everywhere and naturally wraps modulo 256.
    assign dm_addr      = BASE_ADDR + {5'b00000, r_idx};
    assign busy         = (r_state != IDLE);
    assign result_valid = r_valid;
    assign pass         = r_pass;
    assign err_mask     = r_err;
    assign timeout      = w_timeout;

    // Control FSM, expected-table writes and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_exp[i] <= '0;
            end
`ifdef CHECKER_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (exp_we) begin
                        r_exp[exp_idx] <= exp_data;
                    end
                    if (arm) begin
                        r_state <= WAIT_DONE;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
`ifdef CHECKER_TIMEOUT_EN
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        r_state <= SCAN;
`ifdef CHECKER_TIMEOUT_EN
                    end else if (r_cnt == LIMIT) begin
                        r_timeout <= 1'b1;
                        r_state   <= REPORT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
`endif
                    end
                end
                SCAN: begin
                    r_err[r_idx] <= (dm_data != r_exp[r_idx]);
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= REPORT;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                REPORT: begin
                    r_valid <= 1'b1;
                    r_pass  <= (r_err == '0) && !w_timeout;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_result_checker.sv
// Testbench for dm_result_checker: one main instance (defaults, 16-cycle
// watchdog) and one instance placed at the top of the address space to
// exercise address wrap-around. Results are compared against a per-byte
// comparison model of the memory and expected table.
module tb_dm_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, arm, done, exp_we;
    logic [2:0] exp_idx;
    logic [7:0] exp_data, dm_addr, dm_data, err_mask;
    logic       busy, result_valid, pass, timeout;

    logic       arm_w, done_w, exp_we_w;
    logic [2:0] exp_idx_w;
    logic [7:0] exp_data_w, dm_addr_w, dm_data_w, err_mask_w;
    logic       busy_w, result_valid_w, pass_w, timeout_w;

    logic [7:0] mem [256];
    logic [7:0] m_exp [8];
    logic [7:0] m_exp_w [8];

    int total = 0;
    int bad   = 0;

    dm_result_checker #(.NUM_CHECKS(5), .BASE_ADDR(8'd1), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .reset(reset), .arm(arm), .done(done),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
        .dm_addr(dm_addr), .dm_data(dm_data), .busy(busy),
        .result_valid(result_valid), .pass(pass), .err_mask(err_mask),
        .timeout(timeout)
    );

    dm_result_checker #(.NUM_CHECKS(4), .BASE_ADDR(8'd254), .TIMEOUT_CYCLES(16)) u_wrap (
        .clk(clk), .reset(reset), .arm(arm_w), .done(done_w),
        .exp_we(exp_we_w), .exp_idx(exp_idx_w), .exp_data(exp_data_w),
        .dm_addr(dm_addr_w), .dm_data(dm_data_w), .busy(busy_w),
        .result_valid(result_valid_w), .pass(pass_w), .err_mask(err_mask_w),
        .timeout(timeout_w)
    );

    always_comb dm_data   = mem[dm_addr];
    always_comb dm_data_w = mem[dm_addr_w];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_exp[i]   = 8'h00;
            m_exp_w[i] = 8'h00;
        end
    endtask

    task automatic wr_exp(input int idx, input logic [7:0] d);
        exp_we   = 1'b1;
        exp_idx  = idx[2:0];
        exp_data = d;
        tick();
        exp_we   = 1'b0;
        m_exp[idx] = d;
    endtask

    // Full run on the main instance; optional table write coincident with arm.
    task automatic run1(input bit wr, input int widx, input logic [7:0] wdata,
                        output logic [7:0] m, output logic p, output logic to,
                        output int lat);
        arm = 1'b1;
        if (wr) begin
            exp_we   = 1'b1;
            exp_idx  = widx[2:0];
            exp_data = wdata;
            m_exp[widx] = wdata;
        end
        tick();
        arm    = 1'b0;
        exp_we = 1'b0;
        done   = 1'b1;
        tick();
        done = 1'b0;
        lat  = 1;
        while (result_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        m  = err_mask;
        p  = pass;
        to = timeout;
    endtask

    function automatic logic [7:0] model1();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 5; i++)
            if (mem[(1 + i) % 256] != m_exp[i]) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] model_w();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++)
            if (mem[(254 + i) % 256] != m_exp_w[i]) r[i] = 1'b1;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_exp[i]   = 8'h00;
            m_exp_w[i] = 8'h00;
        end
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got busy=%b valid=%b pass=%b to=%b want all 0",
                     busy, result_valid, pass, timeout);
        end
        total++;
        if (err_mask !== 8'h00) begin
            bad++;
            $display("FAIL reset_mask got=%h want=00", err_mask);
        end
        total++;
        if (dm_addr !== 8'd1 || dm_addr_w !== 8'd254) begin
            bad++;
            $display("FAIL reset_addr got=%0d/%0d want=1/254", dm_addr, dm_addr_w);
        end
    endtask

    task automatic test_match();
        logic [7:0] m;
        logic p, to;
        int lat;
        logic [7:0] v [5];
        v = '{8'h57, 8'h55, 8'hAA, 8'h15, 8'h14};
        for (int i = 0; i < 5; i++) begin
            wr_exp(i, v[i]);
            mem[1 + i] = v[i];
        end
        run1(1'b0, 0, 8'h00, m, p, to, lat);
        total++;
        if (m !== 8'h00 || p !== 1'b1 || to !== 1'b0) begin
            bad++;
            $display("FAIL match_result got mask=%h pass=%b to=%b want 00/1/0", m, p, to);
        end
        total++;
        if (lat !== 7) begin
            bad++;
            $display("FAIL match_latency got=%0d want=7", lat);
        end
        total++;
        if (dm_addr !== 8'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL match_idle got addr=%0d busy=%b want 1/0", dm_addr, busy);
        end
    endtask

    task automatic test_mismatch();
        logic [7:0] m;
        logic p, to;
        int lat;
        mem[3] = 8'hAB;
        run1(1'b0, 0, 8'h00, m, p, to, lat);
        total++;
        if (m !== 8'h04 || p !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_result got mask=%h pass=%b want 04/0", m, p);
        end
        total++;
        if (lat !== 7) begin
            bad++;
            $display("FAIL mismatch_latency got=%0d want=7", lat);
        end
        mem[3] = m_exp[2];
    endtask

    task automatic test_done_in_arm_cycle();
        int lat;
        arm  = 1'b1;
        done = 1'b1;
        tick();
        arm  = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_arm_cycle got busy=%b valid=%b want 1/0", busy, result_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        lat  = 1;
        while (result_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 7 || err_mask !== model1() || pass !== (model1() == 8'h00)) begin
            bad++;
            $display("FAIL done_arm_late got lat=%0d mask=%h pass=%b want 7/%h",
                     lat, err_mask, pass, model1());
        end
    endtask

    task automatic test_random();
        logic [7:0] m, want;
        logic p, to;
        int lat;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) wr_exp(i, 8'($urandom));
            for (int i = 0; i < 4; i++)
                mem[1 + i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_exp[i];
            mem[5] = ($urandom_range(0, 1) == 0) ? 8'h3C : 8'($urandom);
            // Entry 4 is written in the same cycle as arm.
            run1(1'b1, 4, 8'h3C, m, p, to, lat);
            want = model1();
            total++;
            if (m !== want || p !== (want == 8'h00) || lat !== 7) begin
                bad++;
                $display("FAIL random_run%0d got mask=%h pass=%b lat=%0d want mask=%h pass=%b lat=7",
                         it, m, p, lat, want, (want == 8'h00));
            end
        end
    endtask

    task automatic test_ignore_busy_inputs();
        int lat;
        for (int i = 0; i < 5; i++) begin
            wr_exp(i, 8'(8'h10 + i));
            mem[1 + i] = 8'(8'h10 + i);
        end
        arm = 1'b1;
        tick();
        arm      = 1'b0;
        exp_we   = 1'b1;
        exp_idx  = 3'd2;
        exp_data = 8'hFF;
        tick();
        exp_we = 1'b0;
        done   = 1'b1;
        tick();
        done = 1'b0;
        arm  = 1'b1;
        tick();
        arm = 1'b0;
        lat = 2;
        while (result_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 7 || err_mask !== 8'h00 || pass !== 1'b1) begin
            bad++;
            $display("FAIL ignore_run got lat=%0d mask=%h pass=%b want 7/00/1", lat, err_mask, pass);
        end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b1 || pass !== 1'b1) begin
            bad++;
            $display("FAIL ignore_hold got busy=%b valid=%b pass=%b want 0/1/1", busy, result_valid, pass);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m, want;
        logic p, to;
        int lat;
        mem[4] = 8'h99;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b1 || err_mask !== 8'h00) begin
            bad++;
            $display("FAIL b2b_clear got valid=%b busy=%b mask=%h want 0/1/00", result_valid, busy, err_mask);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        lat  = 1;
        while (result_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        want = model1();
        total++;
        if (err_mask !== want || pass !== 1'b0 || lat !== 7) begin
            bad++;
            $display("FAIL b2b_first got mask=%h pass=%b lat=%0d want %h/0/7", err_mask, pass, lat, want);
        end
        mem[4] = m_exp[3];
        run1(1'b0, 0, 8'h00, m, p, to, lat);
        total++;
        if (m !== 8'h00 || p !== 1'b1 || lat !== 7) begin
            bad++;
            $display("FAIL b2b_second got mask=%h pass=%b lat=%0d want 00/1/7", m, p, lat);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] m;
        logic p, to;
        int lat;
        for (int i = 0; i < 5; i++) begin
            wr_exp(i, 8'(8'hA0 + i));
            mem[1 + i] = 8'(8'hA0 + i);
        end
        arm = 1'b1;
        tick();
        arm  = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        do_reset();
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || err_mask !== 8'h00) begin
            bad++;
            $display("FAIL midscan_reset got busy=%b valid=%b mask=%h want 0/0/00", busy, result_valid, err_mask);
        end
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midscan_noreport got valid=%b busy=%b want 0/0", result_valid, busy);
        end
        run1(1'b0, 0, 8'h00, m, p, to, lat);
        total++;
        if (m !== 8'h1F || p !== 1'b0 || lat !== 7) begin
            bad++;
            $display("FAIL midscan_cleared_table got mask=%h pass=%b lat=%0d want 1F/0/7", m, p, lat);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want;
        int lat;
        for (int i = 0; i < 4; i++) begin
            exp_we_w   = 1'b1;
            exp_idx_w  = 3'(i);
            exp_data_w = 8'($urandom);
            m_exp_w[i] = exp_data_w;
            tick();
        end
        exp_we_w = 1'b0;
        mem[254] = m_exp_w[0];
        mem[255] = 8'(m_exp_w[1] ^ 8'h01);
        mem[0]   = m_exp_w[2];
        mem[1]   = 8'(m_exp_w[3] ^ 8'h80);
        arm_w = 1'b1;
        tick();
        arm_w  = 1'b0;
        done_w = 1'b1;
        tick();
        done_w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (dm_addr_w !== 8'((254 + k) % 256)) begin
                bad++;
                $display("FAIL wrap_addr%0d got=%0d want=%0d", k, dm_addr_w, (254 + k) % 256);
            end
            tick();
        end
        lat = 5;
        while (result_valid_w !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        want = model_w();
        total++;
        if (err_mask_w !== want || pass_w !== 1'b0 || lat !== 6) begin
            bad++;
            $display("FAIL wrap_result got mask=%h pass=%b lat=%0d want %h/0/6", err_mask_w, pass_w, lat, want);
        end
        total++;
        if (dm_addr_w !== 8'd254) begin
            bad++;
            $display("FAIL wrap_idle_addr got=%0d want=254", dm_addr_w);
        end
    endtask

    task automatic test_timeout();
        arm = 1'b1;
        tick();
        arm = 1'b0;
`ifdef CHECKER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early got to=%b busy=%b want 0/1", timeout, busy);
        end
        tick();
        total++;
        if (timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire got to=%b want 1", timeout);
        end
        tick();
        total++;
        if (result_valid !== 1'b1 || pass !== 1'b0 || err_mask !== 8'h00) begin
            bad++;
            $display("FAIL timeout_report got valid=%b pass=%b mask=%h want 1/0/00", result_valid, pass, err_mask);
        end
`else
        for (int i = 0; i < 40; i++) tick();
        total++;
        if (busy !== 1'b1 || result_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL nowatchdog_wait got busy=%b valid=%b to=%b want 1/0/0", busy, result_valid, timeout);
        end
        do_reset();
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit reached want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; arm = 1'b0; done = 1'b0; exp_we = 1'b0;
        exp_idx = 3'd0; exp_data = 8'h00;
        arm_w = 1'b0; done_w = 1'b0; exp_we_w = 1'b0;
        exp_idx_w = 3'd0; exp_data_w = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        test_reset();
        test_match();
        test_mismatch();
        test_done_in_arm_cycle();
        test_random();
        test_ignore_busy_inputs();
        test_back_to_back();
        test_reset_mid_scan();
        test_wrap();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_result_checker.md
DM_RESULT_CHECKER -- requirements
Module: dm_result_checker

Interface
REQ-001 Parameter NUM_CHECKS, default 5, number of consecutive data-memory bytes checked (legal 1..8).
REQ-002 Parameter BASE_ADDR, default 1, data-memory address of the first checked byte (8-bit).
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, done-wait limit in cycles; used only when the timeout feature is compiled in.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 arm  in  1  single-cycle pulse that starts a check run.
REQ-007 done  in  1  processor completion flag.
REQ-008 exp_we  in  1  expected-table write enable.
REQ-009 exp_idx  in  3  expected-table write index.
REQ-010 exp_data  in  8  expected-table write data.
REQ-011 dm_addr  out  8  data-memory read address.
REQ-012 dm_data  in  8  data-memory read data, combinational from dm_addr (same cycle).
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 result_valid  out  1  pass/err_mask/timeout are final.
REQ-015 pass  out  1  all checked bytes matched and no timeout.
REQ-016 err_mask  out  8  bit i set means byte BASE_ADDR+i mismatched.
REQ-017 timeout  out  1  run ended by watchdog.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_DONE, SCAN and REPORT.
- REQ-019 IDLE: arm=1 -> WAIT_DONE; clears result_valid, pass, err_mask, timeout and the scan index.
- REQ-020 WAIT_DONE: done=1 -> SCAN; done is first sampled in the cycle after arm, so done high in the arm cycle alone does not advance.
- REQ-021 SCAN, index i: dm_addr = (BASE_ADDR+i) mod 256; err_mask[i] <= (dm_data != exp[i]); i increments each cycle.
- REQ-022 SCAN with i = NUM_CHECKS-1 -> REPORT after that cycle's compare.
REQ-023 REPORT SHALL last one cycle and then go to IDLE, setting result_valid=1 and pass=(err_mask==0 && !timeout).
REQ-024 result_valid, pass, err_mask and timeout SHALL hold their values until the next accepted arm or reset.
REQ-025 Latency SHALL be fixed: done sampled high in cycle t -> compares in cycles t+1..t+NUM_CHECKS -> result_valid high from cycle t+NUM_CHECKS+2.
REQ-026 dm_addr SHALL equal BASE_ADDR in IDLE, WAIT_DONE and REPORT.
REQ-027 err_mask bits at index NUM_CHECKS and above SHALL always read 0.
REQ-028 Writes to the expected table SHALL be accepted only in IDLE; exp_we in any other state SHALL be ignored.
REQ-029 exp_we together with arm in IDLE: the write SHALL land before the run starts.
REQ-030 arm while busy SHALL be ignored.
REQ-031 done deasserting during SCAN SHALL NOT abort the scan.

Reset
REQ-032 On reset, the block SHALL enter IDLE, clear the index, clear all 8 expected entries to 0x00, and clear busy, result_valid, pass, err_mask and timeout.
REQ-033 Reset in any state, including mid-SCAN, SHALL abort the run with no result reported.

Configuration
REQ-034 Macro CHECKER_TIMEOUT_EN selects the done watchdog.
- REQ-035 Defined: a cycle counter runs in WAIT_DONE and is cleared on arm. Reaching TIMEOUT_CYCLES without done -> REPORT with timeout=1, pass=0 and err_mask=0.
- REQ-036 Undefined: WAIT_DONE waits indefinitely, no counter is present, and timeout is tied to 0.

Verification
REQ-037 Load exp = {0x57, 0x55, 0xAA, 0x15, 0x14}; memory[1..5] holds the same bytes; arm, then done -> result_valid=1, pass=1, err_mask=0x00, exactly 7 cycles after done.
REQ-038 Same setup but memory[3]=0xAB -> pass=0, err_mask=0x04.
REQ-039 Keep done low after arm with the macro defined and TIMEOUT_CYCLES=16 -> timeout=1, pass=0 after 16 cycles; with the macro undefined -> busy stays 1 and result_valid stays 0.
REQ-040 Assert reset during the 3rd SCAN cycle -> next cycle busy=0, result_valid=0, err_mask=0x00, and all expected entries read back as a mismatch against nonzero memory on a later run.
REQ-041 Pulse arm during SCAN and exp_we with exp_data=0xFF during WAIT_DONE -> the run is unaffected and the expected table is unchanged.
REQ-042 Set BASE_ADDR=254 and NUM_CHECKS=4 -> dm_addr sequence during SCAN is 254, 255, 0, 1.
